// File: rtl/vector_regfile_seq_pkg.sv
// vector_regfile_seq_pkg: shared vector element encodings, FSM states and width helpers
package vector_regfile_seq_pkg;
    localparam int ELEN = 32;
    localparam int MAX_SEW_BYTES = 4;
    typedef enum logic [1:0] {SEW8 = 2'd0, SEW16 = 2'd1, SEW32 = 2'd2, SEW_BAD = 2'd3} vsew_e;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
    function automatic logic [ELEN-1:0] width_mask(input logic [1:0] wcode);
        return wcode == 2'd0 ? ELEN'(8'hFF) : wcode == 2'd1 ? ELEN'(16'hFFFF) : {(MAX_SEW_BYTES*8){1'b1}};
    endfunction
endpackage

// File: rtl/vreg_elem_addr.sv
// vreg_elem_addr: maps an element index and width code to register index, bit offset and liveness
module vreg_elem_addr
    import vector_regfile_seq_pkg::*;
#(
    parameter int VLEN = 32,
    parameter int VL_W = 8,
    parameter int EW   = 11,
    parameter int RIW  = 12
) (
    input  logic [4:0]                base,
    input  logic [EW-1:0]             elem,
    input  logic [1:0]                wcode,
    input  logic [VL_W-1:0]           vl,
    output logic [RIW-1:0]            ridx,
    output logic [$clog2(VLEN)-1:0]   off,
    output logic                      live
);
    localparam int OW = $clog2(VLEN);
    logic [EW+5:0] bitpos;
    // absolute bit position inside the group; width is 8 << wcode
    assign bitpos = {6'd0, elem} << ({1'b0, wcode} + 3'd3);
    assign ridx = RIW'(base) + RIW'(bitpos / (EW+6)'(VLEN));
    assign off = OW'(bitpos % (EW+6)'(VLEN));
    assign live = elem < EW'(vl);
endmodule

// File: rtl/vector_regfile_seq.sv
// vector_regfile_seq: vector register file streaming operand beats out and write-back beats in
module vector_regfile_seq
    import vector_regfile_seq_pkg::*;
#(
    parameter int VLEN  = 32,
    parameter int LANES = 4,
    parameter int NREGS = 32,
    parameter int VL_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [4:0]              req_vs1_addr,
    input  logic [4:0]              req_vs2_addr,
    input  logic [4:0]              req_vd_addr,
    input  logic [1:0]              req_vsew,
    input  logic [VL_W-1:0]         req_vl,
    input  logic                    req_widen,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [LANES*ELEN-1:0]   vs1_data,
    output logic [LANES*ELEN-1:0]   vs2_data,
    output logic [LANES*ELEN-1:0]   vs3_data,
    output logic [LANES-1:0]        rd_lane_en,
    input  logic                    wb_valid,
    output logic                    wb_ready,
    input  logic [LANES*ELEN-1:0]   wb_data,
    input  logic [LANES-1:0]        wb_lane_en,
    output logic                    done,
    output logic                    err
);
    localparam int EW  = VL_W + $clog2(LANES) + 1;
    localparam int RIW = EW + 1;
    localparam int OW  = $clog2(VLEN);
    localparam int RW  = $clog2(NREGS);

    state_e state, state_nxt;
    vsew_e sew_q;
    logic [VLEN-1:0] vreg [NREGS];
    logic [VLEN-1:0] wmask [NREGS];
    logic [VLEN-1:0] wval [NREGS];
    logic [4:0] vs1_q, vs2_q, vd_q;
    logic [VL_W-1:0] vl_q, nb, rd_beat, wb_beat;
    logic widen_q, err_q, illegal, rd_fire, wb_fire;
    logic [1:0] src_w, dst_w;
    logic [2:0][4:0] rbase;
    logic [2:0][1:0] rwc;
    logic [2:0][LANES*ELEN-1:0] rdata;
    logic [LANES-1:0] wen;
    logic [LANES-1:0][RW-1:0] widx;
    logic [LANES-1:0][OW-1:0] woff;

    assign illegal = req_vsew == SEW_BAD || (req_widen && req_vsew == SEW32);
    assign req_ready = reset || state == IDLE;
    assign rd_valid = !reset && state == RUN && rd_beat < nb;
    // write-back may never overtake the beats already read
    assign wb_ready = !reset && state != IDLE && wb_beat < rd_beat;
    assign rd_fire = rd_valid && rd_ready;
    assign wb_fire = wb_valid && wb_ready;
    assign done = !reset && state != IDLE && state_nxt == IDLE;
    assign err = done && err_q;
    assign src_w = sew_q;
    assign dst_w = widen_q ? sew_q + 2'd1 : sew_q;
    assign rbase = {vd_q, vs2_q, vs1_q};
    assign rwc = {dst_w, src_w, src_w};
    assign vs1_data = rdata[0];
    assign vs2_data = rdata[1];
    assign vs3_data = rdata[2];

    always_comb begin
        state_nxt = state == IDLE ? (req_valid ? RUN : IDLE) :
                    state == RUN && rd_beat != nb ? RUN : wb_beat == nb ? IDLE : DRAIN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rd_beat <= '0;
            wb_beat <= '0;
            nb <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            rd_beat <= req_ready && req_valid ? '0 : rd_beat + VL_W'(rd_fire);
            wb_beat <= req_ready && req_valid ? '0 : wb_beat + VL_W'(wb_fire);
            if (req_valid && state == IDLE) begin
                nb <= illegal ? '0 : VL_W'(((VL_W+1)'(req_vl) + (VL_W+1)'(LANES - 1)) / (VL_W+1)'(LANES));
                err_q <= illegal;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_valid && req_ready && !reset) begin
            vs1_q <= req_vs1_addr;
            vs2_q <= req_vs2_addr;
            vd_q <= req_vd_addr;
            sew_q <= vsew_e'(req_vsew);
            vl_q <= req_vl;
            widen_q <= req_widen;
        end
    end

    for (genvar p = 0; p < 3; p++) begin : g_port
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic [RIW-1:0] idx;
            logic [OW-1:0] off;
            logic live;
            logic [VLEN-1:0] word;
            vreg_elem_addr #(.VLEN(VLEN), .VL_W(VL_W), .EW(EW), .RIW(RIW)) u_addr (
                .base(rbase[p]), .elem(EW'(rd_beat) * EW'(LANES) + EW'(i)), .wcode(rwc[p]),
                .vl(vl_q), .ridx(idx), .off(off), .live(live)
            );
            assign word = idx < RIW'(NREGS) ? vreg[idx[RW-1:0]] : '0;
            assign rdata[p][i*ELEN +: ELEN] = rd_valid && live ? ELEN'(word >> off) & width_mask(rwc[p]) : '0;
            if (p == 0) begin : g_en
                assign rd_lane_en[i] = rd_valid && live;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_wb
        logic [RIW-1:0] idx;
        logic [OW-1:0] off;
        logic live;
        vreg_elem_addr #(.VLEN(VLEN), .VL_W(VL_W), .EW(EW), .RIW(RIW)) u_addr (
            .base(vd_q), .elem(EW'(wb_beat) * EW'(LANES) + EW'(i)), .wcode(dst_w),
            .vl(vl_q), .ridx(idx), .off(off), .live(live)
        );
        // register 0 and out-of-range registers silently swallow writes
        assign wen[i] = wb_fire && wb_lane_en[i] && live && idx != '0 && idx < RIW'(NREGS);
        assign widx[i] = idx[RW-1:0];
        assign woff[i] = off;
    end

    // several lanes may land in one register, so merge them into one mask per register
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            wmask[r] = '0;
            wval[r] = '0;
            for (int i = 0; i < LANES; i++) begin
                if (wen[i] && widx[i] == RW'(r)) begin
                    wmask[r] = wmask[r] | (VLEN'(width_mask(dst_w)) << woff[i]);
                    wval[r] = wval[r] | (VLEN'(wb_data[i*ELEN +: ELEN] & width_mask(dst_w)) << woff[i]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NREGS; r++)
            vreg[r] <= reset ? '0 : (vreg[r] & ~wmask[r]) | wval[r];
    end
endmodule

// File: doc/vector_regfile_seq.md
VECTOR_REGFILE_SEQ -- requirements
Module: vector_regfile_seq

Interface
REQ-001 The block SHALL be parameterised as follows, one per line: name, default, meaning.
- VLEN, 32: bits per vector register.
- LANES, 4: elements per beat; LANES*8 SHALL NOT exceed VLEN.
- NREGS, 32: number of vector registers.
- VL_W, 8: width of the vl field.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 The ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk, in, 1: clock.
- reset, in, 1: synchronous active-high reset.
- req_valid / req_ready, in / out, 1 / 1: operation request handshake.
- req_vs1_addr, req_vs2_addr, req_vd_addr, in, 5 each: register-group base addresses.
- req_vsew, in, 2: 0=8b, 1=16b, 2=32b, 3=illegal.
- req_vl, in, VL_W: element count.
- req_widen, in, 1: vd/vs3 element width is 2*SEW.
- rd_valid / rd_ready, out / in, 1 / 1: operand beat handshake.
- vs1_data, vs2_data, vs3_data, out, LANES*32 each: per-lane zero-extended elements.
- rd_lane_en, out, LANES: lane holds a live element.
- wb_valid / wb_ready, in / out, 1 / 1: result beat handshake.
- wb_data, in, LANES*32: per-lane results in the low bits.
- wb_lane_en, in, LANES: lanes to write.
- done, out, 1: one-cycle pulse when the operation completes.
- err, out, 1: qualifies done; the request was illegal.

Function
REQ-004 The FSM SHALL have the states IDLE, RUN and DRAIN; req_ready SHALL be 1 only in IDLE.
REQ-005 On a request handshake, the block SHALL latch all req_* fields and compute NB = ceil(vl/LANES), then go to RUN.
REQ-006 When vl==0, or vsew==3, or (widen && vsew==2), the block SHALL issue no beats and pulse done the next cycle; err SHALL be 1 for the two illegal cases and 0 for vl==0.
REQ-007 Element e of a group SHALL reside in register base + e/(VLEN/W), bits [(e mod (VLEN/W))*W +: W], where W is the element width.
REQ-008 W SHALL be SEW for vs1 and vs2, and 2*SEW for vs3 and vd when widening, otherwise SEW.
REQ-009 Read beat k SHALL present elements k*LANES+i on lane i.
- Dead lanes (element index >= vl) SHALL be driven 0 with rd_lane_en[i]=0.
- A register index >= NREGS SHALL read as 0.
REQ-010 rd_valid SHALL be 1 in RUN while rd_beat < NB.
- rd_beat increments on rd_valid && rd_ready.
- Data SHALL be combinational from the register contents of the current cycle.
- vs1, vs2 and vd data SHALL be held stable while stalled.
REQ-011 wb_ready SHALL be 1 in RUN or DRAIN while wb_beat < NB.
- wb_beat increments on wb_valid && wb_ready.
- wb_beat SHALL never exceed rd_beat; wb_ready SHALL be 0 when wb_beat == rd_beat.
REQ-012 A write-back handshake SHALL write lane i's low W bits to element wb_beat*LANES+i of the vd group in the next cycle, only if wb_lane_en[i] is set and that element index < vl.
REQ-013 Writes to register 0 and to register indices >= NREGS SHALL be suppressed silently.
REQ-014 When rd_beat reaches NB, the FSM SHALL go to DRAIN, or directly to IDLE if wb_beat has also reached NB.
- In DRAIN, the FSM SHALL return to IDLE when wb_beat == NB.
- done SHALL pulse in the cycle the FSM returns to IDLE.
REQ-015 If a read and a write-back to the same register occur in the same cycle, the read SHALL return the old value; there SHALL be no forwarding.
REQ-016 A request presented while req_ready=0 SHALL be ignored without side effects.

Reset
REQ-017 reset SHALL take priority over all other inputs.
REQ-018 Reset SHALL set the FSM to IDLE, both beat counters to 0, and all registers to 0.
REQ-019 The output values under reset SHALL be: req_ready=1; rd_valid=0; wb_ready=0; done=0; err=0; data outputs 0.
REQ-020 Reset asserted mid-operation SHALL abandon the operation with no done pulse.

Structure
REQ-021 The shared vector package SHALL hold the following:
- the vsew encoding enum;
- the state enum (IDLE/RUN/DRAIN);
- the constants ELEN=32 and MAX_SEW_BYTES=4.
REQ-022 The element-address and lane-mask computation SHALL be one sub-module, vreg_elem_addr (element index and width to register index, bit offset and live flag), instantiated once per lane per port.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- vsew=0, vl=4, v2=0x04030201, rd_ready=1: one beat; vs2_data lanes = 1,2,3,4; rd_lane_en=1111; NB=1.
- vsew=2, vl=6, vd=8, wb lanes = 0xA0+i: beat 0 writes v8..v11; beat 1 (lane_en=0011) writes v12 and v13 only; v14 unchanged; done after the second write-back.
- vsew=0, widen=1, vl=4, vd=4: vs3 reads v4/v5 as 16b lanes; a write-back of 0x1234 per lane gives v4=v5=0x12341234.
- vl=0 -> done the next cycle, err=0, no rd_valid; vsew=2 with widen=1 -> done and err=1.
- vd=0, vsew=0, vl=4 with write-back -> v0 remains 0; done still pulses.
- rd_ready toggled 1,0,1 mid-operation -> outputs stable during the stall; reset at beat 1 -> req_ready=1 next cycle, no done, registers cleared.
